// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between the instruction fetch bus (ibus) and
// the load/store data bus (dbus) of the ezpipe core. dbus has priority, but a
// streak counter limits how many dbus grants in a row may pass a waiting ibus
// request. Every memory access is a registered strobe held until mem_ready,
// with a per-access timeout that aborts the access and reports an error.
//
// Parameters
//   DBUS_MAX_BURST : max consecutive dbus grants while ibus is waiting (1..15)
//   TIMEOUT        : cycles an access may wait for mem_ready (1..65535)
//
// Ports
//   clk             : single clock, rising edge
//   reset           : asynchronous, active-low; clears all state and outputs
//   ibus_req/addr   : fetch request, held until ibus_ready or ibus_err
//   ibus_data       : fetched word, valid with ibus_ready (0 otherwise)
//   ibus_ready/err  : one-cycle completion / timeout pulses
//   dbus_rd/wr      : load / store request (both high is illegal)
//   dbus_addr       : load/store address
//   dbus_data_wr    : store data
//   dbus_data_rd    : load data, valid with dbus_data_ready (0 for stores)
//   dbus_data_ready : one-cycle completion pulse
//   dbus_err        : one-cycle pulse on timeout or illegal request
//   mem_addr/wdata  : registered memory address / write data
//   mem_rd/mem_wr   : registered strobes, held until mem_ready or timeout
//   mem_rdata       : read data, sampled on the edge where mem_ready is high
//   mem_ready       : memory completion (ignored while idle)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned DBUS_MAX_BURST = 4,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ibus_req,
    input  logic [31:0] ibus_addr,
    output logic [31:0] ibus_data,
    output logic        ibus_ready,
    output logic        ibus_err,
    input  logic        dbus_rd,
    input  logic        dbus_wr,
    input  logic [31:0] dbus_addr,
    input  logic [31:0] dbus_data_wr,
    output logic [31:0] dbus_data_rd,
    output logic        dbus_data_ready,
    output logic        dbus_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } state_t;

    localparam logic [3:0]  BURST_MAX = 4'(DBUS_MAX_BURST);
    // The timeout counter starts at 0 on the entry edge, so the edge that sees
    // TIMEOUT-1 is the TIMEOUT-th edge after entry.
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic [3:0]  r_streak;
    logic [15:0] r_tmo;

    logic [31:0] r_ibus_data;
    logic        r_ibus_ready;
    logic        r_ibus_err;
    logic [31:0] r_dbus_data_rd;
    logic        r_dbus_ready;
    logic        r_dbus_err;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_rd;
    logic        r_mem_wr;

    logic w_ibus_elig;
    logic w_dbus_elig;
    logic w_dbus_illegal;
    logic w_streak_ok;
    logic w_tmo_expired;

    // A requester is masked during the cycle its own ready/err pulse is out,
    // because its request may still be high from the access just finished.
    assign w_ibus_elig    = ibus_req & ~r_ibus_ready & ~r_ibus_err;
    assign w_dbus_elig    = (dbus_rd | dbus_wr) & ~r_dbus_ready & ~r_dbus_err;
    assign w_dbus_illegal = dbus_rd & dbus_wr;
    assign w_streak_ok    = (r_streak < BURST_MAX);
    assign w_tmo_expired  = (r_tmo == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_streak       <= 4'd0;
            r_tmo          <= 16'd0;
            r_ibus_data    <= 32'd0;
            r_ibus_ready   <= 1'b0;
            r_ibus_err     <= 1'b0;
            r_dbus_data_rd <= 32'd0;
            r_dbus_ready   <= 1'b0;
            r_dbus_err     <= 1'b0;
            r_mem_addr     <= 32'd0;
            r_mem_wdata    <= 32'd0;
            r_mem_rd       <= 1'b0;
            r_mem_wr       <= 1'b0;
        end else begin
            // Response outputs are single-cycle pulses; data is only
            // non-zero alongside its ready pulse.
            r_ibus_ready   <= 1'b0;
            r_ibus_err     <= 1'b0;
            r_ibus_data    <= 32'd0;
            r_dbus_ready   <= 1'b0;
            r_dbus_err     <= 1'b0;
            r_dbus_data_rd <= 32'd0;

            case (r_state)
                IDLE: begin
                    if (w_dbus_elig && w_dbus_illegal) begin
                        // Load and store together: reject without touching
                        // memory. The err pulse masks dbus next cycle, which
                        // lets a waiting ibus request through.
                        r_dbus_err <= 1'b1;
                    end else if (w_dbus_elig && (!w_ibus_elig || w_streak_ok)) begin
                        r_state     <= D_ACC;
                        r_tmo       <= 16'd0;
                        r_mem_addr  <= dbus_addr;
                        r_mem_wdata <= dbus_data_wr;
                        r_mem_rd    <= dbus_rd;
                        r_mem_wr    <= dbus_wr;
                        // Only reached with ibus eligible when the streak is
                        // below the limit, so the increment saturates there.
                        r_streak    <= w_ibus_elig ? (r_streak + 4'd1) : 4'd0;
                    end else if (w_ibus_elig) begin
                        r_state    <= I_ACC;
                        r_tmo      <= 16'd0;
                        r_mem_addr <= ibus_addr;
                        r_mem_rd   <= 1'b1;
                        r_mem_wr   <= 1'b0;
                        r_streak   <= 4'd0;
                    end
                end

                I_ACC, D_ACC: begin
                    if (mem_ready) begin
                        r_state  <= IDLE;
                        r_mem_rd <= 1'b0;
                        r_mem_wr <= 1'b0;
                        if (r_state == I_ACC) begin
                            r_ibus_ready <= 1'b1;
                            r_ibus_data  <= mem_rdata;
                        end else begin
                            r_dbus_ready   <= 1'b1;
                            r_dbus_data_rd <= r_mem_wr ? 32'd0 : mem_rdata;
                        end
                    end else if (w_tmo_expired) begin
                        r_state  <= IDLE;
                        r_mem_rd <= 1'b0;
                        r_mem_wr <= 1'b0;
                        if (r_state == I_ACC) begin
                            r_ibus_err <= 1'b1;
                        end else begin
                            r_dbus_err <= 1'b1;
                        end
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_mem_rd <= 1'b0;
                    r_mem_wr <= 1'b0;
                end
            endcase
        end
    end

    assign ibus_data       = r_ibus_data;
    assign ibus_ready      = r_ibus_ready;
    assign ibus_err        = r_ibus_err;
    assign dbus_data_rd    = r_dbus_data_rd;
    assign dbus_data_ready = r_dbus_ready;
    assign dbus_err        = r_dbus_err;
    assign mem_addr        = r_mem_addr;
    assign mem_wdata       = r_mem_wdata;
    assign mem_rd          = r_mem_rd;
    assign mem_wr          = r_mem_wr;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed scenarios (fetch, store, load-back, timeout, illegal request, reset
// mid-access) followed by a randomized phase. In the random phase the bench
// plays both requesters and the memory: memory contents live in an associative
// array, grant order is predicted from the priority/starvation rules, and each
// access has a chosen latency (or is left to time out).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int MAXB = 4;
    localparam int TMO  = 8;

    logic        clk;
    logic        reset;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic [31:0] ibus_data;
    logic        ibus_ready;
    logic        ibus_err;
    logic        dbus_rd;
    logic        dbus_wr;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_data_wr;
    logic [31:0] dbus_data_rd;
    logic        dbus_data_ready;
    logic        dbus_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_model [logic [31:0]];

    mem_arbiter #(
        .DBUS_MAX_BURST(MAXB),
        .TIMEOUT       (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ibus_req       (ibus_req),
        .ibus_addr      (ibus_addr),
        .ibus_data      (ibus_data),
        .ibus_ready     (ibus_ready),
        .ibus_err       (ibus_err),
        .dbus_rd        (dbus_rd),
        .dbus_wr        (dbus_wr),
        .dbus_addr      (dbus_addr),
        .dbus_data_wr   (dbus_data_wr),
        .dbus_data_rd   (dbus_data_rd),
        .dbus_data_ready(dbus_data_ready),
        .dbus_err       (dbus_err),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_rdata      (mem_rdata),
        .mem_ready      (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // random-phase state
    int          exp_grant;
    int          streak;
    bit          busy;
    int          k;
    int          lat;
    int          resp_k;
    bit          tmo;
    int          owner;
    bit          i_pend;
    bit          d_pend;
    bit          d_wr_q;
    bit          i_masked;
    bit          d_masked;
    bit          ie;
    bit          de;
    logic [31:0] i_addr_q;
    logic [31:0] d_addr_q;
    logic [31:0] d_wdata_q;
    logic [31:0] exp_data;
    int          cnt;

    initial begin
        reset        = 1'b0;
        ibus_req     = 1'b0;
        ibus_addr    = 32'd0;
        dbus_rd      = 1'b0;
        dbus_wr      = 1'b0;
        dbus_addr    = 32'd0;
        dbus_data_wr = 32'd0;
        mem_rdata    = 32'd0;
        mem_ready    = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_mem_rd",    32'(mem_rd), 0);
        chk("rst_mem_wr",    32'(mem_wr), 0);
        chk("rst_mem_addr",  mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_pulses",    32'({ibus_ready, ibus_err, dbus_data_ready, dbus_err}), 0);
        chk("rst_ibus_data", ibus_data, 0);
        chk("rst_dbus_data", dbus_data_rd, 0);
        reset = 1'b1;

        // ---------------- ibus fetch ----------------
        ibus_req  = 1'b1;
        ibus_addr = 32'h40;
        step();
        chk("fetch_rd_c1",  32'(mem_rd), 1);
        chk("fetch_addr",   mem_addr, 32'h40);
        chk("fetch_wr",     32'(mem_wr), 0);
        step();
        chk("fetch_rd_c2",  32'(mem_rd), 1);
        step();
        chk("fetch_rd_c3",  32'(mem_rd), 1);
        chk("fetch_early",  32'(ibus_ready), 0);
        mem_ready = 1'b1;
        mem_rdata = 32'h0050_0093;
        step();
        chk("fetch_ready",  32'(ibus_ready), 1);
        chk("fetch_data",   ibus_data, 32'h0050_0093);
        chk("fetch_rd_off", 32'(mem_rd), 0);
        chk("fetch_noerr",  32'(ibus_err), 0);
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        ibus_req  = 1'b0;
        step();
        chk("fetch_single", 32'(ibus_ready), 0);
        chk("fetch_data0",  ibus_data, 0);

        // ---------------- store ----------------
        dbus_wr      = 1'b1;
        dbus_addr    = 32'h100;
        dbus_data_wr = 32'hDEAD_BEEF;
        step();
        chk("st_wr",    32'(mem_wr), 1);
        chk("st_rd",    32'(mem_rd), 0);
        chk("st_addr",  mem_addr, 32'h100);
        chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        chk("st_ready", 32'(dbus_data_ready), 1);
        chk("st_data0", dbus_data_rd, 0);
        chk("st_wr_off", 32'(mem_wr), 0);
        mem_model[32'h100] = 32'hDEAD_BEEF;
        mem_ready = 1'b0;
        dbus_wr   = 1'b0;
        step();

        // ---------------- load back ----------------
        dbus_rd = 1'b1;
        step();
        chk("ld_rd",   32'(mem_rd), 1);
        chk("ld_addr", mem_addr, 32'h100);
        mem_ready = 1'b1;
        mem_rdata = mem_read(32'h100);
        step();
        chk("ld_ready", 32'(dbus_data_ready), 1);
        chk("ld_data",  dbus_data_rd, 32'hDEAD_BEEF);
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        dbus_rd   = 1'b0;
        step();

        // ---------------- timeout ----------------
        dbus_rd   = 1'b1;
        dbus_addr = 32'h200;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (mem_rd) cnt++;
            else break;
            chk("tmo_quiet", 32'({dbus_data_ready, dbus_err}), 0);
        end
        chk("tmo_len",   cnt, TMO);
        chk("tmo_err",   32'(dbus_err), 1);
        chk("tmo_nordy", 32'(dbus_data_ready), 0);
        chk("tmo_data0", dbus_data_rd, 0);
        dbus_rd   = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        step();
        chk("tmo_err_once", 32'(dbus_err), 0);
        chk("tmo_ign_rdy",  32'(dbus_data_ready), 0);
        chk("tmo_idle_rd",  32'(mem_rd), 0);
        mem_ready = 1'b0;
        step();
        chk("tmo_ign_rdy2", 32'({dbus_data_ready, dbus_err, mem_rd}), 0);

        // ---------------- illegal request ----------------
        dbus_rd   = 1'b1;
        dbus_wr   = 1'b1;
        dbus_addr = 32'h300;
        ibus_req  = 1'b1;
        ibus_addr = 32'h80;
        step();
        chk("ill_err",    32'(dbus_err), 1);
        chk("ill_strobe", 32'({mem_rd, mem_wr}), 0);
        dbus_rd = 1'b0;
        dbus_wr = 1'b0;
        step();
        chk("ill_err_once", 32'(dbus_err), 0);
        chk("ill_i_grant",  32'({mem_rd, mem_wr}), 32'b10);
        chk("ill_i_addr",   mem_addr, 32'h80);
        mem_ready = 1'b1;
        mem_rdata = mem_read(32'h80);
        step();
        chk("ill_i_ready", 32'(ibus_ready), 1);
        chk("ill_i_data",  ibus_data, mem_read(32'h80));
        mem_ready = 1'b0;
        ibus_req  = 1'b0;
        step();

        // ---------------- reset mid-access ----------------
        dbus_rd   = 1'b1;
        dbus_addr = 32'h180;
        step();
        chk("mid_rd1", 32'(mem_rd), 1);
        step();
        chk("mid_rd2",    32'(mem_rd), 1);
        chk("mid_wdata1", mem_wdata, 32'hDEAD_BEEF);
        #2;
        reset     = 1'b0;
        dbus_rd   = 1'b0;
        ibus_req  = 1'b1;
        ibus_addr = 32'h44;
        #1;
        chk("mid_async_rd",   32'(mem_rd), 0);
        chk("mid_async_addr", mem_addr, 0);
        chk("mid_async_wd",   mem_wdata, 0);
        chk("mid_async_puls", 32'({ibus_ready, ibus_err, dbus_data_ready, dbus_err}), 0);
        step();
        chk("mid_held_rst", 32'({mem_rd, dbus_data_ready, dbus_err}), 0);
        reset = 1'b1;
        step();
        chk("mid_i_grant", 32'({mem_rd, mem_wr}), 32'b10);
        chk("mid_i_addr",  mem_addr, 32'h44);
        chk("mid_no_dpul", 32'({dbus_data_ready, dbus_err}), 0);
        mem_ready = 1'b1;
        mem_rdata = mem_read(32'h44);
        step();
        chk("mid_i_ready", 32'(ibus_ready), 1);
        chk("mid_i_data",  ibus_data, mem_read(32'h44));
        mem_ready = 1'b0;
        ibus_req  = 1'b0;
        step();

        // ---------------- randomized traffic ----------------
        reset = 1'b0;
        step();
        reset     = 1'b1;
        exp_grant = 0;
        streak    = 0;
        busy      = 1'b0;
        i_pend    = 1'b0;
        d_pend    = 1'b0;
        owner     = 0;
        tmo       = 1'b0;
        lat       = 0;
        k         = 0;
        resp_k    = 0;
        d_wr_q    = 1'b0;
        i_addr_q  = 32'd0;
        d_addr_q  = 32'd0;
        d_wdata_q = 32'd0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            i_masked  = 1'b0;
            d_masked  = 1'b0;
            mem_ready = 1'b0;
            mem_rdata = $urandom;

            if (busy) begin
                k++;
                if (k == resp_k) begin
                    chk("r_strobe_off", 32'({mem_rd, mem_wr}), 0);
                    if (owner == 1) begin
                        exp_data = tmo ? 32'd0 : mem_read(i_addr_q);
                        chk("r_i_ready", 32'(ibus_ready), 32'(!tmo));
                        chk("r_i_err",   32'(ibus_err), 32'(tmo));
                        chk("r_i_data",  ibus_data, exp_data);
                        chk("r_i_dquiet", 32'({dbus_data_ready, dbus_err}), 0);
                        i_pend   = 1'b0;
                        i_masked = 1'b1;
                        ibus_req = 1'b0;
                    end else begin
                        exp_data = (tmo || d_wr_q) ? 32'd0 : mem_read(d_addr_q);
                        chk("r_d_ready", 32'(dbus_data_ready), 32'(!tmo));
                        chk("r_d_err",   32'(dbus_err), 32'(tmo));
                        chk("r_d_data",  dbus_data_rd, exp_data);
                        chk("r_d_iquiet", 32'({ibus_ready, ibus_err}), 0);
                        if (!tmo && d_wr_q) mem_model[d_addr_q] = d_wdata_q;
                        d_pend   = 1'b0;
                        d_masked = 1'b1;
                        dbus_rd  = 1'b0;
                        dbus_wr  = 1'b0;
                    end
                    busy = 1'b0;
                end else begin
                    chk("b_strobe", 32'({mem_rd, mem_wr}),
                        (owner == 1 || !d_wr_q) ? 32'b10 : 32'b01);
                    chk("b_quiet", 32'({ibus_ready, ibus_err, dbus_data_ready, dbus_err}), 0);
                end
            end else begin
                chk("g_quiet", 32'({ibus_ready, ibus_err, dbus_data_ready, dbus_err}), 0);
                if (exp_grant == 1) begin
                    chk("g_i_strobe", 32'({mem_rd, mem_wr}), 32'b10);
                    chk("g_i_addr",   mem_addr, i_addr_q);
                    owner = 1;
                end else if (exp_grant == 2) begin
                    chk("g_d_strobe", 32'({mem_rd, mem_wr}), d_wr_q ? 32'b01 : 32'b10);
                    chk("g_d_addr",   mem_addr, d_addr_q);
                    chk("g_d_wdata",  mem_wdata, d_wdata_q);
                    owner = 2;
                end else begin
                    chk("g_idle", 32'({mem_rd, mem_wr}), 0);
                end
                if (exp_grant != 0) begin
                    busy   = 1'b1;
                    k      = 0;
                    tmo    = ($urandom_range(0, 11) == 0);
                    lat    = int'($urandom_range(0, 4));
                    resp_k = tmo ? TMO : lat + 1;
                end
            end

            // memory side
            if (busy) begin
                if (!tmo && k == lat) begin
                    mem_ready = 1'b1;
                    if (owner == 1) mem_rdata = mem_read(i_addr_q);
                    else if (!d_wr_q) mem_rdata = mem_read(d_addr_q);
                end
            end else begin
                // stray completions while idle must be ignored
                mem_ready = ($urandom_range(0, 7) == 0);
            end

            // requesters (may re-raise in the cycle of their own pulse)
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend    = 1'b1;
                i_addr_q  = 32'($urandom_range(0, 15)) << 2;
                ibus_req  = 1'b1;
                ibus_addr = i_addr_q;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend       = 1'b1;
                d_wr_q       = 1'($urandom_range(0, 1));
                d_addr_q     = 32'($urandom_range(0, 15)) << 2;
                d_wdata_q    = $urandom;
                dbus_rd      = !d_wr_q;
                dbus_wr      = d_wr_q;
                dbus_addr    = d_addr_q;
                dbus_data_wr = d_wdata_q;
            end

            // predicted winner at the coming edge: dbus first unless it has
            // already passed a waiting ibus MAXB times in a row
            exp_grant = 0;
            if (!busy) begin
                ie = i_pend && !i_masked;
                de = d_pend && !d_masked;
                if (de && (!ie || streak < MAXB)) begin
                    exp_grant = 2;
                    streak    = ie ? streak + 1 : 0;
                end else if (ie) begin
                    exp_grant = 1;
                    streak    = 0;
                end
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
